ccff_loader: RTL
================

# ccff_loader

Configuration-chain load controller that sits directly upstream of the logic-tile configuration chain and drives its `ccff_head` input. It accepts bitstream words over a valid/ready handshake, serialises them LSB-first onto `ccff_head`, and qualifies each chain advance with a shift-enable. It stops after exactly `CHAIN_LEN` bits. An optional readback path compresses `ccff_tail` into a CRC for post-load integrity checks.

## Interface
- `CHAIN_LEN`, 1024: total configuration bits in the chain; legal range 1 to 2^20.
- `WORD_W`, 32: bitstream word width; legal range 8 to 64.
- `prog_clk` in 1: programming clock; all state on rising edge.
- `pReset` in 1: reset, asynchronous, active-low; one clock domain only.
- `start` in 1: single-cycle pulse, honoured only in IDLE.
- `abort` in 1: synchronous abort of an in-progress load.
- `word_data` in WORD_W: bitstream word; bit 0 is shifted first.
- `word_valid` in 1: `word_data` valid.
- `word_ready` out 1: word accepted when `word_valid & word_ready`.
- `ccff_head` out 1: serial data into the chain.
- `ccff_en` out 1: chain-advance qualifier (clock-gate enable for the chain's `prog_clk`).
- `ccff_tail` in 1: serial data out of the chain.
- `busy` out 1: high from the `start` acceptance until DONE or IDLE.
- `done` out 1: single-cycle pulse when bit `CHAIN_LEN` has been shifted.
- `aborted` out 1: sticky; set by `abort`, cleared by the next accepted `start`.
- `bit_count` out clog2(CHAIN_LEN+1): number of bits shifted so far.
- `readback_crc` out 16: only with `CCFF_LOADER_READBACK_EN`.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - On `start`: clear `bit_count`, clear `aborted`, go to LOAD.
  - `start` outside IDLE is ignored.
- LOAD:
  - `word_ready`=1.
  - On handshake: capture `word_data` into the shift register and go to SHIFT.
  - With no valid word, the chain holds (`ccff_en`=0); stalls of any length are legal.
- SHIFT, each cycle:
  - `ccff_head`=sreg[0], `ccff_en`=1.
  - sreg shifts right; `bit_count` increments.
- End-of-word look-ahead, back-to-back with no bubble:
  - On the last bit of a word that is not the chain's last bit, `word_ready`=1.
  - If a handshake occurs that cycle, the next word loads and SHIFT continues.
  - Otherwise the FSM goes to LOAD.
- Chain end:
  - When `bit_count` reaches `CHAIN_LEN`, the FSM goes to DONE regardless of remaining word bits.
  - Leftover bits of a partial final word are discarded.
- DONE: `done` pulses for one cycle, then the FSM goes to IDLE.
- `abort` in LOAD or SHIFT:
  - Next state is IDLE; `ccff_en` drops that cycle.
  - `aborted` is set and `done` is not pulsed.
  - `abort` takes priority over a simultaneous handshake; the word is not consumed.
- Words count is ceil(CHAIN_LEN/WORD_W); `bit_count` saturates at `CHAIN_LEN`.

## Timing
- Reset values: `ccff_head`=0, `ccff_en`=0, `word_ready`=0, `busy`=0, `done`=0, `aborted`=0, `bit_count`=0, `readback_crc`=16'hFFFF.
- All outputs are registered except `word_ready`, which is a combinational decode of state and the last-bit flag.
- Latency:
  - Handshake at cycle t gives the first `ccff_en` at t+1.
  - `done` is asserted one cycle after the final shift cycle.
- Full chain with zero stalls: `start` to `done` takes CHAIN_LEN+2 cycles.
- `ccff_head` and `ccff_en` change together; the chain samples `ccff_head` only while `ccff_en`=1.
- Reset mid-load returns to IDLE immediately. The chain contents are then undefined, and a reload is required.

## Configuration
- Macro: `CCFF_LOADER_READBACK_EN`.
- Defined:
  - `ccff_tail` is sampled on every `ccff_en` cycle into CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first update, no final XOR).
  - The CRC resets on an accepted `start` and is stable from `done` onward.
- Undefined: the `readback_crc` port and its logic are absent; `ccff_tail` is unused.

## Structure
- `ccff_loader_pkg` holds the state enum (`ccff_loader_state_e`), the CRC polynomial/init constants and the `bit_count` width function.
- Sub-module `ccff_loader_crc16` is a 1-bit-per-cycle serial CRC. It is instantiated only under the macro.

## Test plan
- Back-to-back load:
  - Stimulus: CHAIN_LEN=64, WORD_W=32, words 0xA5A5_0F0F then 0x1234_5678, `word_valid` held high.
  - Response: 64 consecutive `ccff_en` cycles with no gap, and the `ccff_head` sequence is the LSB-first bits; `done` at cycle 66 after `start`.
- Partial final word:
  - Stimulus: CHAIN_LEN=40, WORD_W=32.
  - Response: exactly 2 handshakes, 40 `ccff_en` cycles, and the upper 24 bits of word 2 are never driven.
- Stall:
  - Stimulus: deassert `word_valid` for 5 cycles between words.
  - Response: `ccff_en`=0 for those cycles and `bit_count` holds at 32.
- Abort:
  - Stimulus: `abort` at `bit_count`=10 with a simultaneous handshake.
  - Response: IDLE next cycle, `aborted`=1, no `done`, word not consumed; the next `start` clears `aborted`.
- Async reset:
  - Stimulus: `pReset` low mid-SHIFT.
  - Response: all outputs at their reset values without waiting for a clock edge.
- Readback (macro defined):
  - Stimulus: loop `ccff_head` to `ccff_tail` through a 64-bit delay model, then load the chain twice.
  - Response: the second-pass `readback_crc` equals the reference CRC of the first-pass bits.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } ccff_loader_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic int bc_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/ccff_loader_crc16.sv
// Bit-serial CRC-16-CCITT, MSB-first update, one bit per enabled cycle.
module ccff_loader_crc16
  import ccff_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bit_i) ? CRC_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) crc_q <= CRC_INIT;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ccff_loader.sv
// Serialises bitstream words LSB-first onto the config chain head.
// Optional readback CRC of ccff_tail under CCFF_LOADER_READBACK_EN.
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32
) (
  input  logic                             prog_clk,
  input  logic                             pReset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [WORD_W-1:0]                word_data,
  input  logic                             word_valid,
  output logic                             word_ready,
  output logic                             ccff_head,
  output logic                             ccff_en,
  input  logic                             ccff_tail,
  output logic                             busy,
  output logic                             done,
  output logic                             aborted,
  output logic [bc_width(CHAIN_LEN)-1:0]   bit_count
`ifdef CCFF_LOADER_READBACK_EN
  ,
  output logic [15:0]                      readback_crc
`endif
);

  localparam int BC_W  = bc_width(CHAIN_LEN);
  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(CHAIN_LEN - 1);
  localparam logic [BC_W-1:0]  FULL_CNT = BC_W'(CHAIN_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  ccff_loader_state_e state_q;
  logic [WORD_W-1:0]  sreg_q;
  logic [IDX_W-1:0]   idx_q;
  logic [BC_W-1:0]    bit_count_q;
  logic               head_q, en_q, busy_q, done_q, aborted_q;
  logic               last_word, last_chain, accept;

  assign last_word  = (idx_q == LAST_IDX);
  assign last_chain = (bit_count_q == LAST_BIT);
  // Abort masks ready so a concurrent valid word is left with the source.
  assign word_ready = ~abort & ((state_q == S_LOAD) |
                                ((state_q == S_SHIFT) & last_word & ~last_chain));
  assign accept     = word_ready & word_valid;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      idx_q       <= '0;
      bit_count_q <= '0;
      head_q      <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      en_q   <= 1'b0;
      head_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            bit_count_q <= '0;
            aborted_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else if (accept) begin
            sreg_q  <= word_data;
            idx_q   <= '0;
            head_q  <= word_data[0];
            en_q    <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bit_count_q != FULL_CNT) bit_count_q <= bit_count_q + 1'b1;
          if (abort) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else if (last_chain) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (accept) begin
            sreg_q  <= word_data;
            idx_q   <= '0;
            head_q  <= word_data[0];
            en_q    <= 1'b1;
          end else if (last_word) begin
            state_q <= S_LOAD;
          end else begin
            sreg_q <= {1'b0, sreg_q[WORD_W-1:1]};
            idx_q  <= idx_q + 1'b1;
            head_q <= sreg_q[1];
            en_q   <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ccff_head = head_q;
  assign ccff_en   = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign bit_count = bit_count_q;

`ifdef CCFF_LOADER_READBACK_EN
  ccff_loader_crc16 u_crc (
    .clk_i   (prog_clk),
    .rst_ni  (pReset),
    .clear_i ((state_q == S_IDLE) & start),
    .en_i    (en_q),
    .bit_i   (ccff_tail),
    .crc_o   (readback_crc)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule
